// File: rtl/uart_echo_responder.sv
// uart_echo_responder
//   Device-side echo engine for the UART link. Bytes arriving from the UART
//   receiver are queued in a small FIFO and relaunched, in order, through the
//   UART transmitter one frame at a time.
//
//   Optional feature macro: UART_ECHO_UPCASE_EN
//     defined   -> lower-case ASCII ('a'..'z') is folded to upper case on entry
//     undefined -> bytes are echoed bit-exact
//
//   Ports
//     clk, rst     system clock, synchronous active-high reset
//     enable       1 = accept and echo; 0 = drop new bytes, hold launches
//     rx_data      received byte, qualified by rx_ready
//     rx_ready     one-cycle strobe per received byte
//     tx_busy      transmitter busy from uart_top
//     tx_data      byte being transmitted (held from launch to end of frame)
//     tx_start     one-cycle launch strobe
//     fifo_count   FIFO occupancy
//     overflow     sticky: a byte was dropped because the FIFO was full
//     echo_count   number of bytes launched (wraps)
module uart_echo_responder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_W-1:0]              echo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              full_c;
    logic              empty_c;
    logic              push_req_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic [7:0]        wr_byte_c;

    // Byte written into the FIFO (optionally case-folded)
    always_comb begin
        wr_byte_c = rx_data;
`ifdef UART_ECHO_UPCASE_EN
        if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
            wr_byte_c[5] = 1'b0;
        end
`endif
    end

    // Next-state logic and FIFO handshake decisions
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        full_c     = (fifo_count == FCNT_W'(FIFO_DEPTH));
        empty_c    = (fifo_count == '0);
        push_req_c = rx_ready && enable;

        case (state)
            IDLE: begin
                if (!empty_c && enable && !tx_busy) begin
                    state_next = LAUNCH;
                    pop_c      = 1'b1;
                end
            end
            LAUNCH: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pop on the same edge frees the slot a full-FIFO push needs
        push_c = push_req_c && (!full_c || pop_c);
        drop_c = push_req_c && full_c && !pop_c;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage (contents need no reset; pointers and count define validity)
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wr_ptr] <= wr_byte_c;
        end
    end

    // Pointers, occupancy, launch registers and status
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            overflow   <= 1'b0;
            echo_count <= '0;
        end else begin
            tx_start <= pop_c;

            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                tx_data <= mem[rd_ptr];
            end

            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (drop_c) begin
                overflow <= 1'b1;
            end

            if (state == LAUNCH) begin
                echo_count <= echo_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Self-checking bench for uart_echo_responder. A transmitter stub raises
// tx_busy for a programmable frame length after each tx_start; a monitor
// collects every launched byte, and each scenario task compares the
// collected stream against an expected stream built from the echo rules.
module tb_uart_echo_responder;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CNT_W      = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          enable;
    logic [7:0]                    rx_data;
    logic                          rx_ready;
    logic                          tx_busy;
    logic [7:0]                    tx_data;
    logic                          tx_start;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic [CNT_W-1:0]              echo_count;

    int checks   = 0;
    int failures = 0;

    uart_echo_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .echo_count (echo_count)
    );

    initial forever #5 clk = ~clk;

    // Transmitter stub: busy for a frame after each launch, unaffected by rst
    logic stub_force = 1'b0;
    int   stub_len   = 5;
    bit   rnd_len    = 1'b0;
    int   busy_cnt   = 0;

    assign tx_busy = stub_force || (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            busy_cnt <= rnd_len ? int'($urandom_range(1, 6)) : stub_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Monitor: collect launches and flag protocol violations
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         viol       = 0;
    int         peak       = 0;
    logic       prev_busy  = 1'b0;
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (tx_busy || prev_busy || prev_start) viol++;
        end
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        prev_busy  = tx_busy;
        prev_start = tx_start;
    end

    // Expected echo of one byte, straight from the case-folding rule
    function automatic logic [7:0] model(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        repeat (40) tick();
        rst        = 1'b1;
        rx_ready   = 1'b0;
        stub_force = 1'b0;
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        viol = 0;
        peak = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        if (enable) exp_q.push_back(model(b));
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (echo_count !== '0) begin failures++; $display("FAIL reset_echo_count got=%0d exp=0", echo_count); end
    endtask

    task automatic test_latency();
        do_reset();
        rnd_len = 1'b0; stub_len = 10;
        rx_ready = 1'b1; rx_data = 8'hA5;
        tick();
        rx_ready = 1'b0;
        checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL lat_count_n1 got=%0d exp=1", fifo_count); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL lat_start_n1 got=%b exp=0", tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL lat_start_n2 got=%b exp=1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL lat_data got=%h exp=a5", tx_data); end
        tick();
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL lat_start_pulse got=%b exp=0", tx_start); end
        repeat (20) tick();
        checks++; if (echo_count !== 16'd1) begin failures++; $display("FAIL lat_echo_count got=%0d exp=1", echo_count); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL lat_launches got=%0d exp=1", got_q.size()); end
    endtask

    task automatic test_burst();
        do_reset();
        rnd_len = 1'b0; stub_len = 8;
        for (int i = 1; i <= 10; i++) begin
            send_byte(8'(i));
            repeat (14) tick();
        end
        repeat (40) tick();
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_overflow got=%b exp=0", overflow); end
        checks++; if (peak > 2) begin failures++; $display("FAIL burst_peak got=%0d exp<=2", peak); end
        checks++; if (echo_count !== 16'd10) begin failures++; $display("FAIL burst_echo_count got=%0d exp=10", echo_count); end
        checks++; if (viol != 0) begin failures++; $display("FAIL burst_protocol got=%0d exp=0", viol); end
    endtask

    task automatic test_random();
        int total;
        do_reset();
        rnd_len = 1'b1;
        total = 0;
        for (int b = 0; b < 4; b++) begin
            int n;
            n = int'($urandom_range(1, FIFO_DEPTH));
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom));
                total++;
                repeat ($urandom_range(0, 3)) tick();
            end
            repeat (FIFO_DEPTH * 12 + 10) tick();
        end
        rnd_len = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%b exp=0", overflow); end
        checks++; if (int'(echo_count) != total) begin failures++; $display("FAIL rand_echo_count got=%0d exp=%0d", echo_count, total); end
        checks++; if (viol != 0) begin failures++; $display("FAIL rand_protocol got=%0d exp=0", viol); end
    endtask

    task automatic test_enable();
        logic [7:0] a, b;
        do_reset();
        rnd_len = 1'b0; stub_len = 10;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        repeat (10) tick();
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL dis_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL dis_overflow got=%b exp=0", overflow); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL dis_launches got=%0d exp=0", got_q.size()); end
        enable = 1'b1;
        a = 8'($urandom); b = 8'($urandom);
        send_byte(a);
        send_byte(b);
        for (int k = 0; k < 10 && got_q.size() < 1; k++) tick();
        enable = 1'b0;
        repeat (40) tick();
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL hold_launches got=%0d exp=1", got_q.size()); end
        checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", fifo_count); end
        enable = 1'b1;
        repeat (30) tick();
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL resume_launches got=%0d exp=2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== model(a)) begin failures++; $display("FAIL resume_first got=%h exp=%h", got_q[0], model(a)); end
            checks++; if (got_q[1] !== model(b)) begin failures++; $display("FAIL resume_second got=%h exp=%h", got_q[1], model(b)); end
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        rnd_len = 1'b0; stub_len = 5;
        stub_force = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'($urandom));
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", fifo_count); end
        // Release the transmitter on the same edge as the next push
        stub_force = 1'b0;
        send_byte(8'h55);
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL pushpop_count got=%0d exp=8", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pushpop_overflow got=%b exp=0", overflow); end
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL pushpop_start got=%b exp=1", tx_start); end
        repeat (9 * 15) tick();
        checks++; if (got_q.size() != 9) begin failures++; $display("FAIL pushpop_len got=%0d exp=9", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pushpop_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pushpop_overflow_end got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        rnd_len = 1'b0; stub_len = 5;
        stub_force = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        stub_force = 1'b0;
        repeat (8 * 15) tick();
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL ovf_len got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[i], 8'(8'h10 + i)); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rnd_len = 1'b0; stub_len = 20;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        for (int k = 0; k < 10 && got_q.size() < 1; k++) tick();
        repeat (4) tick();
        checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=3", fifo_count); end
        checks++; if (echo_count !== 16'd1) begin failures++; $display("FAIL midrst_pre_echo got=%0d exp=1", echo_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midrst_start got=%b exp=0", tx_start); end
        checks++; if (echo_count !== '0) begin failures++; $display("FAIL midrst_echo got=%0d exp=0", echo_count); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", tx_data); end
        repeat (60) tick();
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL midrst_no_echo got=%0d exp=1", got_q.size()); end
    endtask

    task automatic test_upcase();
        logic [7:0] vec[$];
        do_reset();
        rnd_len = 1'b0; stub_len = 4;
        vec = '{8'h61, 8'h7B, 8'h41, 8'h60, 8'h7A};
        for (int i = 0; i < 4; i++) vec.push_back(8'($urandom_range(8'h5C, 8'h7E)));
        for (int i = 0; i < vec.size(); i++) begin
            send_byte(vec[i]);
            repeat (10) tick();
        end
        repeat (30) tick();
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL case_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL case_byte%0d in=%h got=%h exp=%h", i, vec[i], got_q[i], exp_q[i]); end
        end
        checks++; if (viol != 0) begin failures++; $display("FAIL case_protocol got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_burst();
        test_random();
        test_enable();
        test_full_pushpop();
        test_overflow();
        test_mid_reset();
        test_upcase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end responder for the UART link: consumes bytes delivered by `uart_top`'s receive side (`rx_data`/`rx_ready`) and queues them for retransmission through `uart_top`'s transmit side (`tx_data`/`tx_start`/`tx_busy`). Every accepted byte is echoed back to the initiator in order. A small FIFO absorbs back-to-back received bytes while the transmitter is busy. Instantiated beside `uart_top` on the device end of the RS-232 link; the host-side bench acts as the initiator.

## Interface
- `FIFO_DEPTH`, 8 — echo FIFO entries; power of two, range 2..64.
- `CNT_W`, 16 — width of `echo_count`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = accept and echo bytes; 0 = discard new bytes and hold launches.
- `rx_data`  in  8  received byte from `uart_top`; valid when `rx_ready`=1.
- `rx_ready`  in  1  single-cycle strobe, one per received byte.
- `tx_busy`  in  1  `uart_top` transmitter busy.
- `tx_data`  out  8  byte to transmit; registered, stable from launch until `tx_busy` falls.
- `tx_start`  out  1  single-cycle launch strobe, registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full; cleared only by `rst`.
- `echo_count`  out  CNT_W  number of bytes launched; wraps modulo 2^CNT_W.

## Operation
- Push: `rx_ready`=1 and `enable`=1 writes `rx_data` at the tail, subject to the configuration transform.
- `enable`=0: `rx_ready` bytes are discarded silently; they do not set `overflow`. FIFO contents are retained.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE -> LAUNCH when FIFO not empty, `enable`=1, and `tx_busy`=0. On this edge the head is popped into `tx_data`.
  - LAUNCH: `tx_start`=1 for exactly this cycle; `echo_count` increments. Always -> WAIT_ACK.
  - WAIT_ACK -> WAIT_DONE when `tx_busy`=1.
  - WAIT_DONE -> IDLE when `tx_busy`=0.
- Full FIFO, push with no pop: byte dropped; `overflow` <= 1; `fifo_count` stays at FIFO_DEPTH.
- Full FIFO, push and pop on the same edge: both are performed; no overflow; count is unchanged.
- Empty FIFO, push and IDLE on the same edge: no pop that edge; the new byte launches on the next edge.
- Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `fifo_count` is maintained separately as +1 / −1 / 0.

## Timing
- Reset values: `tx_data`=0x00, `tx_start`=0, `fifo_count`=0, `overflow`=0, `echo_count`=0, FSM=IDLE, pointers=0.
- Reset is honoured in any state, including mid-frame. Outputs return to reset values on the next edge. A frame already started inside `uart_top` is not aborted by this block.
- Latency with an empty FIFO and an idle transmitter:
  - `rx_ready` high in cycle N.
  - `fifo_count`=1 in cycle N+1 (FSM moves to LAUNCH at the end of N+1).
  - `tx_start`=1 in cycle N+2.
- At most one `tx_start` per `tx_busy` high period. A new `tx_start` never occurs within 1 cycle of `tx_busy` falling (IDLE re-check).
- `enable` falling during WAIT_ACK or WAIT_DONE lets the current byte finish; no further launches occur.

## Configuration
- `UART_ECHO_UPCASE_EN` defined: bytes 0x61–0x7A ('a'–'z') have bit 5 cleared before being written to the FIFO, so they are echoed as 'A'–'Z'. All other values pass unchanged.
- Not defined: all bytes are echoed bit-exact; no transform logic is present.

## Test plan
- Single byte, loopback through `uart_top` (10 MHz clock, 1 Mbaud): host sends 0xA5 -> device `tx_start` 2 cycles after `rx_ready`, `tx_data`=0xA5; host receives 0xA5; `echo_count`=1.
- Burst: host sends 0x01..0x0A back-to-back, FIFO_DEPTH=8 -> all 10 echoed in order with `overflow`=0, because the echo drains while receiving; peak `fifo_count` ≤ 2.
- Overflow: hold `tx_busy`=1 via a bench stub, inject 9 `rx_ready` strobes 0x10..0x18 -> `fifo_count`=8, `overflow`=1. After releasing `tx_busy`, 0x10..0x17 are echoed and 0x18 is lost.
- Full plus simultaneous push/pop: FIFO at 8, FSM popping on the same edge as a push of 0x55 -> `fifo_count` stays 8, `overflow` stays 0, 0x55 echoed last.
- Mid-operation reset: assert `rst` for 1 cycle during WAIT_DONE with 3 bytes queued -> next cycle `fifo_count`=0, `tx_start`=0, `echo_count`=0; no further echo.
- Macro: with `UART_ECHO_UPCASE_EN`, send 0x61, 0x7B, 0x41 -> echoes 0x41, 0x7B, 0x41. Without the macro -> 0x61, 0x7B, 0x41.
